elm_hidden_accum: RTL and testbench
===================================

// Module: elm_hidden_accum
// PURPOSE
//  Downstream consumer of the RF_top1 stimulus stream; runs in the clk2 domain.
//  Accepts 16-bit stimulus samples, each paired with an 11-bit LFSR random weight.
//  For each of NUM_NODES hidden neurons, forms the signed MAC over NUM_TAPS samples,
//  scales it, applies ReLU, and pushes the result into a small output buffer.
//  The next ELM stage drains that buffer through a valid/ready handshake.
// PARAMETERS
//  DATA_W     16  stimulus width, signed two's complement
//  WGT_W      11  weight width, signed two's complement (LFSR value reinterpreted)
//  ACC_W      32  accumulator width, signed, saturating
//  NUM_TAPS   128 samples per neuron (the clk1/clk2 ratio)
//  NUM_NODES  12  neurons per frame, one per LFSR enable
//  SHIFT      8   arithmetic right shift applied before activation
//  OUT_W      16  result width, unsigned (post-ReLU)
//  OBUF_DEPTH 4   output buffer entries
// PORTS
//  clk2          in   1       clock, rising edge
//  reset_an2     in   1       asynchronous active-low reset
//  soft_clear    in   1       synchronous clear of acc, counters, buffer and ovf
//  in_valid      in   1       stimulus/weight pair valid
//  in_ready      out  1       block can accept a pair
//  in_stimulus   in   DATA_W  stimulus sample (out_stimulus)
//  in_weight     in   WGT_W   random weight (lfsr_random)
//  node_valid    out  1       output buffer non-empty
//  node_ready    in   1       consumer pops the head entry
//  node_data     out  OUT_W   head result
//  node_index    out  4       head neuron index, 0..NUM_NODES-1
//  frame_done    out  1       1-cycle pulse when the result of neuron NUM_NODES-1 is pushed
//  ovf           out  1       sticky: accumulator saturated at least once
// BEHAVIOUR
//  Reset (async, reset_an2=0):
//   - state=IDLE; acc=0; tap_cnt=0; node_cnt=0; buffer empty.
//   - Outputs: in_ready=1, node_valid=0, node_data=0, node_index=0, frame_done=0, ovf=0.
//  Handshakes:
//   - Input transfer when in_valid & in_ready.
//   - Output pop when node_valid & node_ready.
//   - node_data/node_index are stable while node_valid=1 and node_ready=0.
//  FSM:
//   - IDLE->ACCUM on the first transfer.
//   - ACCUM->FINISH on transfer number NUM_TAPS (tap_cnt==NUM_TAPS-1).
//   - FINISH->IDLE unconditionally after 1 cycle.
//  Accumulate:
//   - On every transfer: acc <= sat(acc + sext(in_stimulus*in_weight)).
//   - The full signed product is DATA_W+WGT_W bits wide.
//   - The first tap of a neuron loads the product, not acc+product.
//  FINISH cycle:
//   - r = acc >>> SHIFT; r<0 -> 0; r>2^OUT_W-1 -> 2^OUT_W-1.
//   - Push {node_cnt, r}; node_cnt increments, wrapping NUM_NODES-1 -> 0 (frame_done=1 this cycle).
//  Latency: node_valid rises 2 clk2 edges after the edge that accepted the last tap (empty buffer).
//  in_ready = (state!=FINISH) && (buffer count < OBUF_DEPTH).
//   - This guarantees FINISH always has space; the push is never dropped.
//  Buffer:
//   - Push and pop in the same cycle is allowed; count is unchanged.
//   - A pop when empty is ignored.
//  Saturation:
//   - On signed overflow, acc clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and ovf sets.
//   - ovf clears only on reset or soft_clear.
//  soft_clear:
//   - Behaves like reset on the next edge and has priority over a transfer in the same cycle.
//   - in_ready=0 during the soft_clear cycle.
//  Reset or soft_clear mid-neuron: the partial sum is discarded and the next transfer is tap 0 of neuron 0.
// TESTING
//  1) stim=100, wgt=3 for 128 taps -> acc=38400; node_data=150, node_index=0; node_valid 2 cycles after last tap.
//  2) stim=256, wgt=11'h7FF (-1) for 128 taps -> acc=-32768; node_data=0 (ReLU); ovf=0.
//  3) stim=16'h7FFF, wgt=11'h3FF for 128 taps -> acc saturates to 2^31-1; ovf=1; node_data=65535.
//  4) node_ready=0, stream 5 neurons -> 4 entries buffered; in_ready=0 after the 4th FINISH;
//     one pop re-enables in_ready; no data lost; indices in order 0,1,2,3,4.
//  5) Stream 12 neurons with node_ready=1 -> indices 0..11; frame_done pulses once on node 11;
//     the 13th neuron carries index 0.
//  6) reset_an2 low at tap 60, released, then 128 taps of stim=1, wgt=1 -> node_data=0
//     (128>>>8); index=0; no stale entry.

Source files
------------

// File: rtl/elm_hidden_accum.sv
// Small synchronous FIFO used as the hidden-node result buffer.
// Latency: a push is visible at the head one edge later. Backpressure: pushes are dropped when full,
// so the owner must keep its own occupancy below DEPTH. Pops are ignored when empty.
module elm_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk2,
  input  logic          reset_an2,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [CW-1:0] cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != CW'(DEPTH)) || do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_dat;
      wr_d        = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
    end
    if (do_pop) begin
      rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk2 or negedge reset_an2) begin
    if (!reset_an2) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_dat = mem_q[rd_q];
  assign cnt      = cnt_q;
endmodule

// ELM hidden layer: per neuron, saturating signed MAC over NUM_TAPS stimulus/weight pairs, >>>SHIFT, ReLU.
// Latency: result at node_valid 2 edges after the edge accepting the last tap (empty buffer).
// Backpressure: in_ready low in FINISH, during soft_clear, or when buffer plus in-flight result is full.
module elm_hidden_accum #(
  parameter int DATA_W     = 16,
  parameter int WGT_W      = 11,
  parameter int ACC_W      = 32,
  parameter int NUM_TAPS   = 128,
  parameter int NUM_NODES  = 12,
  parameter int SHIFT      = 8,
  parameter int OUT_W      = 16,
  parameter int OBUF_DEPTH = 4
) (
  input  logic              clk2,
  input  logic              reset_an2,
  input  logic              soft_clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_stimulus,
  input  logic [WGT_W-1:0]  in_weight,
  output logic              node_valid,
  input  logic              node_ready,
  output logic [OUT_W-1:0]  node_data,
  output logic [3:0]        node_index,
  output logic              frame_done,
  output logic              ovf
);
  localparam int PROD_W = DATA_W + WGT_W;
  localparam int TAP_W  = $clog2(NUM_TAPS);
  localparam int NODE_W = 4;
  localparam int ENT_W  = NODE_W + OUT_W;
  localparam int CW     = $clog2(OBUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_e;

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [TAP_W-1:0]         tap_q, tap_d;
  logic [NODE_W-1:0]        node_q, node_d;
  logic                     ovf_q, ovf_d;
  logic                     pend_vld_q, pend_vld_d;
  logic [ENT_W-1:0]         pend_dat_q, pend_dat_d;
  logic                     frame_done_q, frame_done_d;

  logic [PROD_W-1:0]        stim_ext, wgt_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  base;
  logic signed [ACC_W:0]    sum;
  logic signed [ACC_W-1:0]  acc_sat;
  logic                     acc_ovf;
  logic signed [ACC_W-1:0]  shifted;
  logic [OUT_W-1:0]         relu;
  logic                     in_xfer;
  logic                     fifo_clr;
  logic                     fifo_pop;
  logic [ENT_W-1:0]         head_dat;
  logic [CW-1:0]            obuf_cnt;
  logic [CW:0]              occupancy;

  // Sum kept one bit wider than the accumulator so overflow shows up as a sign disagreement.
  always_comb begin
    stim_ext = {{WGT_W{in_stimulus[DATA_W-1]}}, in_stimulus};
    wgt_ext  = {{DATA_W{in_weight[WGT_W-1]}}, in_weight};
    prod     = $signed(stim_ext) * $signed(wgt_ext);
    base     = (tap_q == '0) ? '0 : acc_q;
    sum      = $signed({base[ACC_W-1], base})
             + $signed({{(ACC_W + 1 - PROD_W){prod[PROD_W-1]}}, prod});
    acc_ovf  = sum[ACC_W] ^ sum[ACC_W-1];
    if (!acc_ovf) begin
      acc_sat = sum[ACC_W-1:0];
    end else if (sum[ACC_W]) begin
      acc_sat = {1'b1, {(ACC_W - 1){1'b0}}};
    end else begin
      acc_sat = {1'b0, {(ACC_W - 1){1'b1}}};
    end
    shifted = acc_q >>> SHIFT;
    if (shifted[ACC_W-1]) begin
      relu = '0;
    end else if (|shifted[ACC_W-2:OUT_W]) begin
      relu = '1;
    end else begin
      relu = shifted[OUT_W-1:0];
    end
  end

  // The in-flight result counts as occupied so FINISH can never find the buffer full.
  always_comb begin
    occupancy = {1'b0, obuf_cnt} + {{CW{1'b0}}, pend_vld_q};
    in_ready  = !soft_clear && (state_q != FINISH) && (occupancy < (CW + 1)'(OBUF_DEPTH));
    in_xfer   = in_valid && in_ready;
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    tap_d        = tap_q;
    node_d       = node_q;
    ovf_d        = ovf_q;
    pend_vld_d   = 1'b0;
    pend_dat_d   = pend_dat_q;
    frame_done_d = 1'b0;
    fifo_clr     = 1'b0;
    if (soft_clear) begin
      state_d    = IDLE;
      acc_d      = '0;
      tap_d      = '0;
      node_d     = '0;
      ovf_d      = 1'b0;
      pend_dat_d = '0;
      fifo_clr   = 1'b1;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (in_xfer) begin
            acc_d = acc_sat;
            if (acc_ovf) ovf_d = 1'b1;
            if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
              tap_d   = '0;
              state_d = FINISH;
            end else begin
              tap_d   = tap_q + 1'b1;
              state_d = ACCUM;
            end
          end
        end
        FINISH: begin
          pend_vld_d = 1'b1;
          pend_dat_d = {node_q, relu};
          if (node_q == NODE_W'(NUM_NODES - 1)) begin
            node_d       = '0;
            frame_done_d = 1'b1;
          end else begin
            node_d = node_q + 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk2 or negedge reset_an2) begin
    if (!reset_an2) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      tap_q        <= '0;
      node_q       <= '0;
      ovf_q        <= 1'b0;
      pend_vld_q   <= 1'b0;
      pend_dat_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      tap_q        <= tap_d;
      node_q       <= node_d;
      ovf_q        <= ovf_d;
      pend_vld_q   <= pend_vld_d;
      pend_dat_q   <= pend_dat_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fifo_pop = node_valid && node_ready;

  elm_fifo #(
    .W     (ENT_W),
    .DEPTH (OBUF_DEPTH),
    .CW    (CW)
  ) u_obuf (
    .clk2      (clk2),
    .reset_an2 (reset_an2),
    .clr       (fifo_clr),
    .push      (pend_vld_q),
    .push_dat  (pend_dat_q),
    .pop       (fifo_pop),
    .head_dat  (head_dat),
    .cnt       (obuf_cnt)
  );

  always_comb begin
    node_valid = (obuf_cnt != '0);
    if (node_valid) begin
      {node_index, node_data} = head_dat;
    end else begin
      node_index = '0;
      node_data  = '0;
    end
  end

  assign frame_done = frame_done_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_elm_hidden_accum.sv
// Directed bench for elm_hidden_accum: arithmetic model plus per-cycle compare and literal spot checks.
module tb_elm_hidden_accum;
  logic        clk2 = 1'b0;
  logic        reset_an2, soft_clear, in_valid, in_ready;
  logic [15:0] in_stimulus;
  logic [10:0] in_weight;
  logic        node_valid, node_ready, frame_done, ovf;
  logic [15:0] node_data;
  logic [3:0]  node_index;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;

  typedef struct {
    int idx;
    int dat;
    int avail;
  } ent_t;

  ent_t   mq[$];
  longint m_acc;
  int     m_tap, m_node, fin_cyc, fd_cyc;
  bit     m_ovf;
  int     log_idx[$];
  int     log_dat[$];
  int     fd_cnt;

  elm_hidden_accum dut (
    .clk2        (clk2),
    .reset_an2   (reset_an2),
    .soft_clear  (soft_clear),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_stimulus (in_stimulus),
    .in_weight   (in_weight),
    .node_valid  (node_valid),
    .node_ready  (node_ready),
    .node_data   (node_data),
    .node_index  (node_index),
    .frame_done  (frame_done),
    .ovf         (ovf)
  );

  always #5 clk2 = ~clk2;
  always @(posedge clk2) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    m_acc = 0; m_tap = 0; m_node = 0; m_ovf = 0;
    mq.delete();
    fin_cyc = -10; fd_cyc = -10;
  endfunction

  // Called one half-cycle before the edge that takes the tap.
  function automatic void model_tap(input logic [15:0] s, input logic [10:0] w);
    longint p, r;
    ent_t   e;
    p = longint'($signed(s)) * longint'($signed(w));
    m_acc = (m_tap == 0) ? p : m_acc + p;
    if (m_acc > AMAX) begin m_acc = AMAX; m_ovf = 1; end
    else if (m_acc < AMIN) begin m_acc = AMIN; m_ovf = 1; end
    m_tap++;
    if (m_tap == 128) begin
      r = m_acc >>> 8;
      if (r < 0) r = 0;
      if (r > 65535) r = 65535;
      e.idx = m_node; e.dat = int'(r); e.avail = cyc + 3;
      mq.push_back(e);
      fin_cyc = cyc + 1;
      if (m_node == 11) fd_cyc = cyc + 2;
      m_node = (m_node + 1) % 12;
      m_tap = 0;
    end
  endfunction

  always @(negedge clk2) begin : cmp
    bit exp_nv;
    bit exp_rdy;
    if (!reset_an2) begin
      chk("rst_node_valid", node_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_node_data", node_data, 0);
      chk("rst_node_index", node_index, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_ovf", ovf, 0);
      model_clear();
    end else begin
      exp_nv  = (mq.size() > 0) && (mq[0].avail <= cyc);
      exp_rdy = !soft_clear && (cyc != fin_cyc) && (mq.size() < 4);
      chk("node_valid", node_valid, exp_nv);
      chk("node_data", node_data, exp_nv ? mq[0].dat : 0);
      chk("node_index", node_index, exp_nv ? mq[0].idx : 0);
      chk("in_ready", in_ready, exp_rdy);
      chk("ovf", ovf, m_ovf);
      chk("frame_done", frame_done, cyc == fd_cyc);
      if (frame_done) fd_cnt++;
      if (soft_clear) begin
        model_clear();
      end else begin
        if (exp_nv && node_ready) begin
          log_idx.push_back(int'(node_index));
          log_dat.push_back(int'(node_data));
          void'(mq.pop_front());
        end
        if (in_valid && exp_rdy) model_tap(in_stimulus, in_weight);
      end
    end
  end

  task automatic send_tap(input logic [15:0] s, input logic [10:0] w);
    int guard = 0;
    in_valid = 1'b1; in_stimulus = s; in_weight = w;
    do begin
      @(negedge clk2);
      guard++;
    end while (!in_ready && guard < 2000);
    if (!in_ready) begin
      errors++;
      $display("FAIL send_tap_timeout: in_ready stayed 0 for %0d cycles, required 1", guard);
    end
    @(posedge clk2); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_neuron(input logic [15:0] s, input logic [10:0] w);
    for (int i = 0; i < 128; i++) send_tap(s, w);
  endtask

  task automatic drain();
    @(posedge clk2); #1 node_ready = 1'b1;
    repeat (8) @(posedge clk2);
    #1 node_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk2); #1 reset_an2 = 1'b0;
    repeat (2) @(negedge clk2);
    @(posedge clk2); #1 reset_an2 = 1'b1;
    log_idx.delete(); log_dat.delete(); fd_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_an2 = 1'b0; soft_clear = 1'b0; in_valid = 1'b0;
    in_stimulus = '0; in_weight = '0; node_ready = 1'b0; fd_cnt = 0;
    model_clear();
    repeat (3) @(negedge clk2);
    @(posedge clk2); #1 reset_an2 = 1'b1;

    // 1) 100*3*128 = 38400 -> 150, with latency pinned
    send_neuron(16'd100, 11'd3);
    @(negedge clk2); chk("t1_finish_in_ready", in_ready, 0); chk("t1_nv_e0", node_valid, 0);
    @(negedge clk2); chk("t1_nv_e1", node_valid, 0);
    @(negedge clk2); chk("t1_nv_e2", node_valid, 1);
    drain();
    chk("t1_count", log_dat.size(), 1);
    chk("t1_data", log_dat[0], 150);
    chk("t1_index", log_idx[0], 0);

    // 2) 256*(-1)*128 = -32768 -> ReLU 0
    log_idx.delete(); log_dat.delete();
    send_neuron(16'd256, 11'h7FF);
    drain();
    chk("t2_data", log_dat[0], 0);
    chk("t2_index", log_idx[0], 1);
    chk("t2_ovf", ovf, 0);

    // 3) saturating accumulator -> 65535, ovf sticky
    log_idx.delete(); log_dat.delete();
    send_neuron(16'h7FFF, 11'h3FF);
    drain();
    chk("t3_data", log_dat[0], 65535);
    chk("t3_ovf", ovf, 1);

    // soft_clear mid-neuron wins over a simultaneous transfer and clears ovf
    log_idx.delete(); log_dat.delete();
    for (int i = 0; i < 30; i++) send_tap(16'd1000, 11'd500);
    soft_clear = 1'b1; in_valid = 1'b1; in_stimulus = 16'h7FFF; in_weight = 11'h3FF;
    @(negedge clk2); chk("sc_in_ready", in_ready, 0);
    @(posedge clk2); #1 soft_clear = 1'b0; in_valid = 1'b0;
    @(negedge clk2); chk("sc_ovf", ovf, 0);
    send_neuron(16'd4, 11'd2);
    drain();
    chk("sc_count", log_dat.size(), 1);
    chk("sc_data", log_dat[0], 4);
    chk("sc_index", log_idx[0], 0);

    // 4) buffer fills with node_ready=0, one pop releases the fifth neuron
    do_reset();
    for (int n = 0; n < 4; n++) send_neuron(16'(10 * (n + 1)), 11'd2);
    repeat (3) @(negedge clk2);
    chk("t4_full_in_ready", in_ready, 0);
    chk("t4_full_nv", node_valid, 1);
    fork
      send_neuron(16'd50, 11'd2);
      begin
        repeat (5) @(negedge clk2);
        chk("t4_stall_in_ready", in_ready, 0);
        @(posedge clk2); #1 node_ready = 1'b1;
        @(posedge clk2); #1 node_ready = 1'b0;
      end
    join
    repeat (4) @(negedge clk2);
    drain();
    chk("t4_count", log_idx.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_index%0d", i), log_idx[i], i);
      chk($sformatf("t4_data%0d", i), log_dat[i], 10 * (i + 1));
    end

    // 5) full frame of 12 plus one, consumer always ready
    do_reset();
    node_ready = 1'b1;
    for (int n = 0; n < 13; n++) send_neuron(16'(n + 1), 11'd256);
    repeat (6) @(negedge clk2);
    @(posedge clk2); #1 node_ready = 1'b0;
    chk("t5_count", log_idx.size(), 13);
    for (int i = 0; i < 13; i++) chk($sformatf("t5_index%0d", i), log_idx[i], i % 12);
    chk("t5_data5", log_dat[5], 768);
    chk("t5_frame_done_pulses", fd_cnt, 1);

    // 6) reset mid-neuron discards the partial sum
    do_reset();
    for (int i = 0; i < 60; i++) send_tap(16'd1000, 11'd7);
    do_reset();
    send_neuron(16'd1, 11'd1);
    drain();
    chk("t6_count", log_idx.size(), 1);
    chk("t6_data", log_dat[0], 0);
    chk("t6_index", log_idx[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
